// File: rtl/control_state_machine.sv
// rtl/control_state_machine.sv - multicycle main control FSM with halt, illegal-opcode and debug counters
// Drives the control decoder state input; instr_done marks the final step of each instruction.

module control_state_machine #(
    parameter int COUNT_WIDTH     = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   halt_req,
    output logic [3:0]             state,
    output logic                   instr_done,
    output logic                   halted,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF                   = 4'd0,
        S_REGISTER_FETCH       = 4'd1,
        S_IMMEDIATE_INJECTION2 = 4'd2,
        S_ALU_R3               = 4'd3,
        S_ALU_RI3              = 4'd4,
        S_ALU4                 = 4'd5,
        S_BRANCH3              = 4'd6,
        S_MEMORY_REF3          = 4'd7,
        S_LOAD4                = 4'd8,
        S_STORE4               = 4'd9,
        S_LOAD5                = 4'd10,
        S_JUMP3                = 4'd11,
        S_HALT                 = 4'd12
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic                   illegal_q;
    logic [COUNT_WIDTH-1:0] cycle_count_q;
    logic [COUNT_WIDTH-1:0] instr_count_q;
    logic [COUNT_WIDTH-1:0] cycle_count_d;
    logic [COUNT_WIDTH-1:0] instr_count_d;

    state_t rf_target_d;
    logic   op_illegal;
    logic   final_step;

    // Opcode class decode; only consulted while in REGISTER_FETCH.
    always_comb begin
        rf_target_d = S_IF;
        op_illegal  = 1'b0;
        casez (opcode)
            6'b00????: rf_target_d = S_ALU_R3;
            6'b01????: rf_target_d = S_ALU_RI3;
            6'b100???: rf_target_d = S_MEMORY_REF3;
            6'b101???: rf_target_d = S_BRANCH3;
            6'b110000: rf_target_d = S_JUMP3;
            6'b110001: rf_target_d = S_IMMEDIATE_INJECTION2;
            6'b111111: rf_target_d = S_HALT;
            default: begin
                op_illegal  = 1'b1;
                rf_target_d = HALT_ON_ILLEGAL ? S_HALT : S_IF;
            end
        endcase
    end

    // An illegal opcode retired as a NOP makes REGISTER_FETCH the final step.
    always_comb begin
        final_step = 1'b0;
        case (state_q)
            S_ALU4, S_BRANCH3, S_STORE4, S_LOAD5, S_JUMP3, S_IMMEDIATE_INJECTION2:
                final_step = 1'b1;
            S_REGISTER_FETCH:
                final_step = op_illegal && !HALT_ON_ILLEGAL;
            default:
                final_step = 1'b0;
        endcase
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != S_HALT) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
        end
        if (final_step) begin
            instr_count_d = instr_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IF;
            illegal_q     <= 1'b0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            if (final_step) begin
                state_q <= halt_req ? S_HALT : S_IF;
            end else begin
                case (state_q)
                    S_IF:             state_q <= S_REGISTER_FETCH;
                    S_REGISTER_FETCH: begin
                        state_q <= rf_target_d;
                        if (op_illegal) begin
                            illegal_q <= 1'b1;
                        end
                    end
                    S_ALU_R3,
                    S_ALU_RI3:        state_q <= S_ALU4;
                    S_MEMORY_REF3:    state_q <= opcode[2] ? S_STORE4 : S_LOAD4;
                    S_LOAD4:          state_q <= S_LOAD5;
                    S_HALT:           state_q <= S_HALT;
                    default:          state_q <= S_IF;
                endcase
            end
        end
    end

    assign state       = state_q;
    assign instr_done  = final_step;
    assign halted      = (state_q == S_HALT);
    assign illegal_op  = illegal_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule
